// File: rtl/bpu_btb_pkg.sv
// Shared definitions for the branch target buffer: counter encodings,
// counter reset state, instruction step and the core instruction-address width.
package bpu_btb_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_STEP       = 4;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  localparam cnt_e CNT_RST = CNT_WNT;

endpackage

// File: rtl/bpu_sat_cnt2.sv
// 2-bit saturating counter next-state function and its taken decision.
module bpu_sat_cnt2
  import bpu_btb_pkg::*;
(
  input  cnt_e cnt_i,
  input  logic taken_i,
  output cnt_e cnt_o,
  output logic pred_o
);

  assign pred_o = cnt_i[1];

  // Step one state toward the resolved outcome, holding at either end
  always_comb begin
    cnt_o = cnt_i;
    case (cnt_i)
      CNT_SNT: cnt_o = taken_i ? CNT_WNT : CNT_SNT;
      CNT_WNT: cnt_o = taken_i ? CNT_WT  : CNT_SNT;
      CNT_WT:  cnt_o = taken_i ? CNT_ST  : CNT_WNT;
      default: cnt_o = taken_i ? CNT_ST  : CNT_WT;
    endcase
  end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with per-entry 2-bit counters.
// Combinational lookup from fetch, training from EX, perf counters.
// Optional gshare indexing with a global history register: BPU_GSHARE_EN.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int unsigned ADDR_W    = INST_ADDR_BUS_W,
  parameter int unsigned BTB_DEPTH = 16,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned GHR_W     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              lkp_valid_i,
  input  logic [ADDR_W-1:0] lkp_pc_i,
  output logic              prd_hit_o,
  output logic              prd_taken_o,
  output logic [ADDR_W-1:0] prd_target_o,
  output logic [GHR_W-1:0]  prd_ghr_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_is_br_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic [GHR_W-1:0]  upd_ghr_i,
  output logic [31:0]       perf_upd_o,
  output logic [31:0]       perf_miss_o
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

  logic [BTB_DEPTH-1:0] valid_q;
  logic [BTB_DEPTH-1:0] uncond_q;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];
  cnt_e                 cnt_q [BTB_DEPTH];

  logic [31:0] perf_upd_q, perf_miss_q;

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_hit, lkp_pred, lkp_taken;
  logic             upd_hit, upd_pred, upd_cnt_pred, upd_acc, upd_misp;
  cnt_e             upd_cnt_nxt, lkp_cnt_unused;
  logic             unused_bits;

  assign lkp_tag = lkp_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign lkp_idx     = lkp_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign upd_idx     = upd_pc_i[IDX_W+1:2] ^ IDX_W'(upd_ghr_i);
  assign prd_ghr_o   = ghr_q;
  assign unused_bits = ^upd_pc_i;

  // History: rebuilt from the lookup-time snapshot on a mispredict, else shifted by branches
  always_comb begin
    ghr_d = ghr_q;
    if (upd_acc) begin
      if (upd_misp) begin
        ghr_d = GHR_W'({upd_ghr_i, upd_taken_i});
      end else if (upd_is_br_i) begin
        ghr_d = GHR_W'({ghr_q, upd_taken_i});
      end
    end
  end

  // History register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign lkp_idx     = lkp_pc_i[IDX_W+1:2];
  assign upd_idx     = upd_pc_i[IDX_W+1:2];
  assign prd_ghr_o   = '0;
  assign unused_bits = ^{upd_pc_i, upd_ghr_i};
`endif

  bpu_sat_cnt2 u_lkp_cnt (
    .cnt_i   (cnt_q[lkp_idx]),
    .taken_i (1'b0),
    .cnt_o   (lkp_cnt_unused),
    .pred_o  (lkp_pred)
  );

  bpu_sat_cnt2 u_upd_cnt (
    .cnt_i   (cnt_q[upd_idx]),
    .taken_i (upd_taken_i),
    .cnt_o   (upd_cnt_nxt),
    .pred_o  (upd_cnt_pred)
  );

  assign lkp_hit      = lkp_valid_i & valid_q[lkp_idx] & (tag_q[lkp_idx] == lkp_tag);
  assign lkp_taken    = lkp_hit & (uncond_q[lkp_idx] | lkp_pred);
  assign prd_hit_o    = lkp_hit;
  assign prd_taken_o  = lkp_taken;
  assign prd_target_o = lkp_taken ? tgt_q[lkp_idx] : lkp_pc_i + ADDR_W'(INST_STEP);

  assign upd_hit  = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_pred = upd_hit & (uncond_q[upd_idx] | upd_cnt_pred);
  assign upd_acc  = upd_valid_i & ~stall_i & ~flush_i;
  assign upd_misp = upd_pred != upd_taken_i;

  // Table: flush clears valids; accepted updates train a hit or allocate on a taken miss
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= '0;
      uncond_q <= '0;
      for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_RST;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_acc) begin
      if (upd_hit) begin
        if (upd_is_br_i) begin
          cnt_q[upd_idx] <= upd_cnt_nxt;
        end else begin
          uncond_q[upd_idx] <= 1'b1;
          cnt_q[upd_idx]    <= CNT_ST;
        end
        if (upd_taken_i) tgt_q[upd_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        valid_q[upd_idx]  <= 1'b1;
        uncond_q[upd_idx] <= ~upd_is_br_i;
        tag_q[upd_idx]    <= upd_tag;
        tgt_q[upd_idx]    <= upd_target_i;
        cnt_q[upd_idx]    <= upd_is_br_i ? CNT_WT : CNT_ST;
      end
    end
  end

  // Performance counters over accepted updates
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_upd_q  <= '0;
      perf_miss_q <= '0;
    end else if (upd_acc) begin
      perf_upd_q <= perf_upd_q + 32'd1;
      if (upd_misp) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_upd_o  = perf_upd_q;
  assign perf_miss_o = perf_miss_q;

endmodule

// File: tb/tb_bpu_btb.sv
// Scoreboard bench for bpu_btb: directed scenarios plus random traffic
// checked against an entry-level behavioural model.
module tb_bpu_btb;

  localparam int unsigned AW = 32, DEPTH = 16, TW = 8, GW = 4, IW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          stall_i, flush_i, lkp_valid_i;
  logic [AW-1:0] lkp_pc_i, prd_target_o, upd_pc_i, upd_target_i;
  logic          prd_hit_o, prd_taken_o, upd_valid_i, upd_is_br_i, upd_taken_i;
  logic [GW-1:0] prd_ghr_o, upd_ghr_i;
  logic [31:0]   perf_upd_o, perf_miss_o;

  always #5 clk = ~clk;

  bpu_btb #(.ADDR_W(AW), .BTB_DEPTH(DEPTH), .TAG_W(TW), .GHR_W(GW)) dut (
    .clk(clk), .rstn(rstn), .stall_i(stall_i), .flush_i(flush_i),
    .lkp_valid_i(lkp_valid_i), .lkp_pc_i(lkp_pc_i),
    .prd_hit_o(prd_hit_o), .prd_taken_o(prd_taken_o),
    .prd_target_o(prd_target_o), .prd_ghr_o(prd_ghr_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_br_i(upd_is_br_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .upd_ghr_i(upd_ghr_i),
    .perf_upd_o(perf_upd_o), .perf_miss_o(perf_miss_o)
  );

  typedef struct {
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    logic [3:0]  ghr;
    logic [31:0] pu;
    logic [31:0] pm;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: one record per table slot
  bit          m_val[DEPTH];
  bit          m_unc[DEPTH];
  int          m_tag[DEPTH];
  int          m_cnt[DEPTH];
  logic [31:0] m_tgt[DEPTH];
  int          m_ghr;
  logic [31:0] m_upd, m_miss;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 32'(DEPTH));
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc >> (2 + IW)) % (32'd1 << TW));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_val[i] = 0; m_unc[i] = 0; m_tag[i] = 0; m_cnt[i] = 1; m_tgt[i] = 0;
    end
    m_ghr = 0; m_upd = 0; m_miss = 0;
  endfunction

  function automatic exp_t model_lookup(logic [31:0] pc);
    exp_t e;
    int   i = idx_of(pc);
`ifdef BPU_GSHARE_EN
    i = i ^ m_ghr;
`endif
    e.hit = m_val[i] && (m_tag[i] == tag_of(pc));
    e.tk  = e.hit && (m_unc[i] || m_cnt[i] >= 2);
    e.tgt = e.tk ? m_tgt[i] : pc + 32'd4;
    e.ghr = 4'(m_ghr);
    e.pu  = m_upd;
    e.pm  = m_miss;
    return e;
  endfunction

  function automatic void model_update(logic [31:0] pc, bit br, bit tk, logic [31:0] tgt, int g);
    int i = idx_of(pc);
    int t = tag_of(pc);
    bit h, pred;
`ifdef BPU_GSHARE_EN
    i = i ^ g;
`endif
    h    = m_val[i] && (m_tag[i] == t);
    pred = h && (m_unc[i] || m_cnt[i] >= 2);
    m_upd = m_upd + 1;
    if (pred != tk) m_miss = m_miss + 1;
`ifdef BPU_GSHARE_EN
    if (pred != tk) m_ghr = (g * 2 + int'(tk)) % 16;
    else if (br)    m_ghr = (m_ghr * 2 + int'(tk)) % 16;
`endif
    if (h) begin
      if (br) m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      else begin m_unc[i] = 1; m_cnt[i] = 3; end
      if (tk) m_tgt[i] = tgt;
    end else if (tk) begin
      m_val[i] = 1; m_unc[i] = !br; m_tag[i] = t; m_tgt[i] = tgt; m_cnt[i] = br ? 2 : 3;
    end
  endfunction

  // One cycle of stimulus; expected lookup response goes to the scoreboard
  task automatic cyc(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                     input bit br, input bit tk, input logic [31:0] tgt, input int g,
                     input bit st, input bit fl);
    @(negedge clk);
    lkp_valid_i = lv; lkp_pc_i = lpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_is_br_i = br; upd_taken_i = tk;
    upd_target_i = tgt; upd_ghr_i = 4'(g); stall_i = st; flush_i = fl;
    if (lv) sbq.push_back(model_lookup(lpc));
    if (fl) begin
      for (int i = 0; i < int'(DEPTH); i++) m_val[i] = 0;
    end else if (uv && !st) begin
      model_update(upc, br, tk, tgt, g);
    end
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1, pc, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    #2;
  endtask

  task automatic upd(input logic [31:0] pc, input bit br, input bit tk, input logic [31:0] tgt,
                     input int g, input bit st, input bit fl);
    cyc(0, 32'h0, 1, pc, br, tk, tgt, g, st, fl);
  endtask

  // Reset pulse, optionally with an update pending across the reset edge
  task automatic do_reset(input bit mid_upd);
    @(negedge clk);
    lkp_valid_i = 0; upd_valid_i = mid_upd; upd_pc_i = 32'h100; upd_is_br_i = 1;
    upd_taken_i = 1; upd_target_i = 32'h80; upd_ghr_i = '0; stall_i = 0; flush_i = 0;
    #1 rstn = 0;
    @(negedge clk);
    upd_valid_i = 0;
    #1 rstn = 1;
    model_reset();
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFFC003);
    return pc;
  endfunction

  // Monitor: compare every presented lookup against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn && lkp_valid_i) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("hit", prd_hit_o, e.hit);
          chk("taken", prd_taken_o, e.tk);
          chk("target", prd_target_o, e.tgt);
          chk("ghr", prd_ghr_o, e.ghr);
          chk("perf_upd", perf_upd_o, e.pu);
          chk("perf_miss", perf_miss_o, e.pm);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    int          g;
    stall_i = 0; flush_i = 0; lkp_valid_i = 0; lkp_pc_i = 0; upd_valid_i = 0;
    upd_pc_i = 0; upd_is_br_i = 0; upd_taken_i = 0; upd_target_i = 0; upd_ghr_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rstn = 1;

`ifndef BPU_GSHARE_EN
    look(32'h100);
    chk("rst_hit", prd_hit_o, 0); chk("rst_taken", prd_taken_o, 0);
    chk("rst_target", prd_target_o, 32'h104);
    chk("rst_perf_upd", perf_upd_o, 0); chk("rst_perf_miss", perf_miss_o, 0);

    upd(32'h100, 1, 1, 32'h80, 0, 0, 0);
    look(32'h100);
    chk("alloc_hit", prd_hit_o, 1); chk("alloc_taken", prd_taken_o, 1);
    chk("alloc_target", prd_target_o, 32'h80);
    chk("alloc_perf_upd", perf_upd_o, 1); chk("alloc_perf_miss", perf_miss_o, 1);

    repeat (3) upd(32'h100, 1, 0, 32'h0, 0, 0, 0);
    look(32'h100);
    chk("nt_taken", prd_taken_o, 0); chk("nt_target", prd_target_o, 32'h104);
    chk("nt_perf_miss", perf_miss_o, 2); chk("nt_perf_upd", perf_upd_o, 4);

    look(32'h140);
    chk("alias_hit", prd_hit_o, 0);
    upd(32'h140, 1, 1, 32'h200, 0, 0, 0);
    look(32'h100);
    chk("replaced_old_hit", prd_hit_o, 0);
    look(32'h140);
    chk("replaced_new_hit", prd_hit_o, 1); chk("replaced_new_target", prd_target_o, 32'h200);

    upd(32'h140, 1, 1, 32'h300, 0, 0, 1);
    look(32'h140);
    chk("flush_hit", prd_hit_o, 0); chk("flush_perf_upd", perf_upd_o, 5);

    upd(32'h140, 1, 1, 32'h300, 0, 1, 0);
    look(32'h140);
    chk("stall_hit", prd_hit_o, 0); chk("stall_perf_upd", perf_upd_o, 5);

    look(32'hFFFFFFFC);
    chk("wrap_target", prd_target_o, 32'h0);
`else
    look(32'h100);
    chk("rst_ghr", prd_ghr_o, 0); chk("rst_hit", prd_hit_o, 0);
    upd(32'h100, 1, 1, 32'h80, 0, 0, 0);
    upd(32'h100, 1, 1, 32'h80, 1, 0, 0);
    look(32'h100);
    chk("gs_ghr_3", prd_ghr_o, 4'b0011); chk("gs_idx3_hit", prd_hit_o, 0);
    upd(32'h100, 1, 0, 32'h0, 0, 0, 0);
    look(32'h100);
    chk("gs_ghr_restore", prd_ghr_o, 4'b0000); chk("gs_idx0_hit", prd_hit_o, 1);
    chk("gs_idx0_taken", prd_taken_o, 0); chk("gs_perf_miss", perf_miss_o, 3);
`endif

    do_reset(1);
    look(32'h100);
    chk("midrst_hit", prd_hit_o, 0); chk("midrst_perf_upd", perf_upd_o, 0);

    for (int n = 0; n < 3000; n++) begin
      a = rnd_pc();
      b = rnd_pc();
      g = ($urandom_range(0, 1) == 1) ? m_ghr : int'($urandom_range(0, 15));
      cyc($urandom_range(0, 9) < 8, a, $urandom_range(0, 9) < 6, b,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, g,
          $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    @(negedge clk);
    lkp_valid_i = 0; upd_valid_i = 0; stall_i = 0; flush_i = 0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
